// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch address, issues sequential word reads to a
// 1-cycle-latency instruction memory, and buffers {pc, instr} pairs in a
// small circular FIFO for decode. A redirect reloads the fetch address and
// flushes everything buffered or in flight.
//
// Handshake: an entry transfers to decode in any cycle where out_valid and
// out_ready are both 1 at the rising edge; out_valid never depends on
// out_ready, and the head entry stays stable until it is accepted.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   pend_pc_q, pend_pc_d;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Advance a FIFO pointer, wrapping at DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check uses registered state only: a same-cycle pop does not free space.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue     = reset && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0) && !redirect;
  assign out_pc    = out_valid ? pc_mem[head_q]    : 32'h0;
  assign out_instr = out_valid ? instr_mem[head_q] : 32'h0;
  assign count     = count_q;

  // Next-state for fetch address, pointers, occupancy and the pending request.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = issue;
    pend_pc_d  = pend_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pend_pc_d  = fetch_pc_q;
      end
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers; reset takes priority over redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // FIFO storage: the returning response is written at the tail.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[tail_q]    <= pend_pc_q;
      instr_mem[tail_q] <= imem_rdata;
    end
  end

  // A push into a full FIFO means the credit rule has been broken.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      assert (count_q < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: reset hold/release, streaming,
// backpressure, redirect flush, address wrap-around and reset priority.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks;
  int n_errors;

  localparam logic [31:0] K = 32'hA5A5_0000;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .count       (count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: one-cycle read latency, instr = addr ^ K
  initial imem_rdata = 32'h0;
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ K) : 32'h0;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
    chk({tag, "_pc"},    out_pc,    pc);
    chk({tag, "_instr"}, out_instr, pc ^ K);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"},  {31'b0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  // one reset cycle, then release with the given out_ready; returns at cycle 0
  task automatic restart(input logic rdy);
    cyc();
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    #1;
    cyc();
    reset = 1'b1; out_ready = rdy;
    #1;
    chk("rst_count", {29'b0, count}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // reset hold
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("hold_req",   {31'b0, imem_req},  32'h0);
      chk("hold_valid", {31'b0, out_valid}, 32'h0);
      chk("hold_count", {29'b0, count},     32'h0);
      chk("hold_pc",    out_pc,             32'h0);
      chk("hold_instr", out_instr,          32'h0);
    end

    // release with out_ready=1: streaming
    reset = 1'b1; out_ready = 1'b1; #1;
    chk_req("s0", 32'h0000_3000);
    chk("s0_valid", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk_req("s1", 32'h0000_3004);
    chk("s1_valid", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk_req("s2", 32'h0000_3008);
    chk_out("s2", 32'h0000_3000);
    cyc(); #1;
    chk_req("s3", 32'h0000_300C);
    chk_out("s3", 32'h0000_3004);
    chk("s3_count", {29'b0, count}, 32'h1);
    cyc(); #1;
    chk_out("s4", 32'h0000_3008);
    cyc(); #1;
    chk_out("s5", 32'h0000_300C);

    // wrap-around redirect while streaming
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("w0_valid", {31'b0, out_valid}, 32'h0);
    chk("w0_req",   {31'b0, imem_req},  32'h0);
    cyc(); redirect = 1'b0; #1;
    chk_req("w1", 32'hFFFF_FFFC);
    chk("w1_count", {29'b0, count}, 32'h0);
    cyc(); #1;
    chk_req("w2", 32'h0000_0000);
    chk("w2_valid", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk_out("w3", 32'hFFFF_FFFC);
    chk_req("w3", 32'h0000_0004);
    cyc(); #1;
    chk_out("w4", 32'h0000_0000);

    // backpressure
    restart(1'b0);
    chk_req("b0", 32'h0000_3000);
    cyc(); #1; chk_req("b1", 32'h0000_3004);
    cyc(); #1; chk_req("b2", 32'h0000_3008);
    chk_out("b2", 32'h0000_3000);
    cyc(); #1; chk_req("b3", 32'h0000_300C);
    chk("b3_count", {29'b0, count}, 32'h2);
    cyc(); #1;
    chk("b4_req",   {31'b0, imem_req}, 32'h0);
    chk("b4_count", {29'b0, count},    32'h3);
    cyc(); #1;
    chk("b5_req",   {31'b0, imem_req}, 32'h0);
    chk("b5_count", {29'b0, count},    32'h4);
    chk_out("b5", 32'h0000_3000);
    cyc(); out_ready = 1'b1; #1;
    chk("b6_req",   {31'b0, imem_req}, 32'h0);
    chk_out("b6", 32'h0000_3000);
    cyc(); #1;
    chk_req("b7", 32'h0000_3010);
    chk_out("b7", 32'h0000_3004);
    chk("b7_count", {29'b0, count}, 32'h3);
    cyc(); #1;
    chk_req("b8", 32'h0000_3014);
    chk_out("b8", 32'h0000_3008);
    chk("b8_count", {29'b0, count}, 32'h2);
    cyc(); #1; chk_out("b9", 32'h0000_300C);
    cyc(); #1; chk_out("b10", 32'h0000_3010);
    cyc(); #1; chk_out("b11", 32'h0000_3014);

    // redirect flush with count=3, inflight=1
    restart(1'b0);
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_3403; #1;
    chk("r0_count", {29'b0, count},     32'h3);
    chk("r0_valid", {31'b0, out_valid}, 32'h0);
    chk("r0_req",   {31'b0, imem_req},  32'h0);
    chk("r0_pc",    out_pc,             32'h0);
    cyc(); redirect = 1'b0; out_ready = 1'b1; #1;
    chk("r1_count", {29'b0, count},     32'h0);
    chk("r1_valid", {31'b0, out_valid}, 32'h0);
    chk_req("r1", 32'h0000_3400);
    cyc(); #1;
    chk("r2_valid", {31'b0, out_valid}, 32'h0);
    chk_req("r2", 32'h0000_3404);
    cyc(); #1; chk_out("r3", 32'h0000_3400);
    cyc(); #1; chk_out("r4", 32'h0000_3404);

    // reset has priority over a simultaneous redirect
    restart(1'b0);
    cyc(); #1;
    cyc(); #1;
    cyc(); reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_5000; #1;
    chk("p0_count", {29'b0, count},    32'h2);
    chk("p0_req",   {31'b0, imem_req}, 32'h0);
    cyc(); reset = 1'b1; redirect = 1'b0; out_ready = 1'b1; #1;
    chk("p1_count", {29'b0, count},     32'h0);
    chk("p1_valid", {31'b0, out_valid}, 32'h0);
    chk_req("p1", 32'h0000_3000);
    cyc(); #1; chk_req("p2", 32'h0000_3004);
    cyc(); #1; chk_out("p3", 32'h0000_3000);
    cyc(); #1; chk_out("p4", 32'h0000_3004);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
